// File: rtl/party_pkg.sv
// Shared definitions for the key event FIFO: register map, EVENT word layout and the
// queued entry type.
package party_pkg;

  localparam logic [1:0] AddrStatus  = 2'd0;
  localparam logic [1:0] AddrEvent   = 2'd1;
  localparam logic [1:0] AddrControl = 2'd2;
  localparam logic [1:0] AddrClear   = 2'd3;

  localparam int unsigned EvtKeyLsb   = 0;
  localparam int unsigned EvtPressBit = 2;
  localparam int unsigned EvtTsLsb    = 8;
  localparam int unsigned EvtValidBit = 31;

  typedef struct packed {
    logic [15:0] ts;
    logic        press;
    logic [1:0]  key;
  } key_event_t;

  function automatic logic [31:0] pack_event(key_event_t e);
    logic [31:0] w;
    w                    = '0;
    w[EvtKeyLsb +: 2]    = e.key;
    w[EvtPressBit]       = e.press;
    w[EvtTsLsb +: 16]    = e.ts;
    w[EvtValidBit]       = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/key_event_fifo_if.sv
// Avalon-MM slave bus plus interrupt line of the key event FIFO.
interface key_event_fifo_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, inversion to active-high, and a stability
// counter that emits a one-cycle change pulse when the accepted level flips.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable,
  output logic change
);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES : 2);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            change_q, change_d;
  logic            synced;

  assign synced = sync_q[1];

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    change_d = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = synced;
        change_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      change_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], ~key_n};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      change_q <= change_d;
    end
  end

  assign stable = stable_q;
  assign change = change_q;

endmodule

// File: rtl/key_event_fifo.sv
// Debounced push-button event queue with an Avalon-MM register interface and level irq.
// Optional KEY_EVENT_TIMESTAMP_EN adds a millisecond timestamp to every queued event.
module key_event_fifo
  import party_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [3:0] KEY,
  key_event_fifo_if.slave avs
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  logic [3:0] stable, change;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (CLOCK_50),
      .rst_n (reset_n),
      .key_n (KEY[i]),
      .stable(stable[i]),
      .change(change[i])
    );
  end

  logic [15:0] ts;
`ifdef KEY_EVENT_TIMESTAMP_EN
  localparam logic [15:0] MsTicks = 16'd50000;
  logic [15:0] prescale_q, ms_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      ms_q       <= '0;
    end else if (prescale_q == MsTicks - 16'd1) begin
      prescale_q <= '0;
      ms_q       <= ms_q + 16'd1;
    end else begin
      prescale_q <= prescale_q + 16'd1;
    end
  end
  assign ts = ms_q;
`else
  assign ts = '0;
`endif

  logic [3:0]      pending_q, pending_d, press_q, press_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     readdata_q, rdata;
  logic            irq_q;
  key_event_t      mem_q [FIFO_DEPTH];

  logic       push_vld, do_push, pop, clear, wr_ctrl;
  logic [1:0] push_idx;
  key_event_t new_evt;
  logic       unused_wdata;

  assign unused_wdata = ^avs.avs_writedata[31:2];
  assign wr_ctrl = avs.avs_write && (avs.avs_address == AddrControl);
  assign clear   = avs.avs_write && (avs.avs_address == AddrClear) && avs.avs_writedata[0];
  assign pop     = avs.avs_read && (avs.avs_address == AddrEvent) && (count_q != '0);

  // Descending scan so the lowest pending index is the one selected.
  always_comb begin
    push_vld = 1'b0;
    push_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_vld = 1'b1;
        push_idx = 2'(i);
      end
    end
  end

  assign new_evt = '{ts: ts, press: press_q[push_idx], key: push_idx};
  // A pop frees a slot in the same cycle, so full+pop still accepts the push.
  assign do_push = push_vld && !clear && ((count_q != CntFull) || pop);

  always_comb begin
    pending_d = pending_q;
    press_d   = press_q;
    if (push_vld) pending_d[push_idx] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (change[i] && (stable[i] || ctrl_q[1])) begin
        pending_d[i] = 1'b1;
        press_d[i]   = stable[i];
      end
    end
    if (clear) pending_d = '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ctrl_d   = wr_ctrl ? avs.avs_writedata[1:0] : ctrl_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !pop)      count_d = count_q + CntW'(1);
      else if (!do_push && pop) count_d = count_q - CntW'(1);
      if (push_vld && (count_q == CntFull) && !pop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (avs.avs_address)
      AddrStatus:  rdata = {15'd0, ovf_q, 8'd0, 4'(count_q), stable};
      AddrEvent:   rdata = (count_q != '0) ? pack_event(mem_q[rd_ptr_q]) : 32'd0;
      AddrControl: rdata = {30'd0, ctrl_q};
      AddrClear:   rdata = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_ptr_q] <= new_evt;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      press_q    <= '0;
      ctrl_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      press_q    <= press_d;
      ctrl_q     <= ctrl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      readdata_q <= avs.avs_read ? rdata : 32'd0;
      irq_q      <= ctrl_q[0] && (count_q != '0);
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign avs.irq          = irq_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Randomized scoreboard bench for key_event_fifo against a queue-based event model.
module tb_key_event_fifo;
  localparam int unsigned Deb   = 4;
  localparam int unsigned Depth = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key   = 4'hF;

  always #5 clk = ~clk;

  key_event_fifo_if bus();

  key_event_fifo #(
    .DEBOUNCE_CYCLES(Deb),
    .FIFO_DEPTH     (Depth)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (rst_n),
    .KEY     (key),
    .avs     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        rsp_pending;

  // Reference model: accepted key levels, control bits, overflow and queued event words.
  logic [3:0]  m_stable = 4'd0;
  logic [1:0]  m_ctrl   = 2'd0;
  logic        m_ovf    = 1'b0;
  logic [31:0] m_fifo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_pending <= 1'b0;
    else        rsp_pending <= bus.avs_read;
  end

  always @(negedge clk) begin
    if (rsp_pending) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %08h expected no response", bus.avs_readdata);
      end else begin
        check("readdata", bus.avs_readdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] status_word();
    return {15'd0, m_ovf, 8'd0, 4'(m_fifo.size()), m_stable};
  endfunction

  task automatic model_keys(input logic [3:0] pressed);
    logic [31:0] ev;
    for (int i = 0; i < 4; i++) begin
      if (pressed[i] != m_stable[i] && (pressed[i] || m_ctrl[1])) begin
        ev = 32'h8000_0000 | {29'd0, pressed[i], 2'(i)};
        if (m_fifo.size() == Depth) m_ovf = 1'b1;
        else                        m_fifo.push_back(ev);
      end
    end
    m_stable = pressed;
  endtask

  task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp);
    @(negedge clk);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
    if (addr == 2'd2) m_ctrl = data[1:0];
    if (addr == 2'd3 && data[0]) begin
      m_fifo.delete();
      m_ovf = 1'b0;
    end
  endtask

  task automatic read_event();
    logic [31:0] e;
    e = (m_fifo.size() != 0) ? m_fifo.pop_front() : 32'd0;
    bus_read(2'd1, e);
  endtask

  task automatic read_status();
    bus_read(2'd0, status_word());
  endtask

  task automatic set_keys(input logic [3:0] pressed);
    model_keys(pressed);
    @(negedge clk);
    key = ~pressed;
    repeat (25) @(negedge clk);
  endtask

  task automatic glitch(input logic [3:0] mask, input int len);
    @(negedge clk);
    key = key ^ mask;
    repeat (len) @(negedge clk);
    key = key ^ mask;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_irq();
    repeat (3) @(negedge clk);
    check("irq", {31'd0, bus.irq}, {31'd0, m_ctrl[0] && (m_fifo.size() != 0)});
  endtask

  initial begin
    int r;
    bus.avs_address   = 2'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_readdata", bus.avs_readdata, 32'd0);
    check("reset_irq", {31'd0, bus.irq}, 32'd0);
    rst_n = 1'b1;
    read_status();

    // Single press with irq enabled, then release (release events disabled).
    bus_write(2'd2, 32'd1);
    set_keys(4'b0100);
    read_status();
    check_irq();
    read_event();
    check_irq();
    set_keys(4'b0000);

    // Short glitch must not register.
    glitch(4'b0001, 2);
    read_status();

    // Simultaneous presses queue in index order.
    set_keys(4'b1001);
    read_status();
    read_event();
    read_event();
    set_keys(4'b0000);

    // Overflow: six presses into a four-entry queue.
    set_keys(4'b1111);
    set_keys(4'b0000);
    set_keys(4'b0011);
    read_status();
    repeat (5) read_event();
    set_keys(4'b0000);
    bus_write(2'd3, 32'd1);
    read_status();

    // Release events, then CLEAR with events queued.
    bus_write(2'd2, 32'd2);
    set_keys(4'b0010);
    set_keys(4'b0000);
    read_event();
    read_event();
    set_keys(4'b0100);
    set_keys(4'b0000);
    read_status();
    bus_write(2'd3, 32'd1);
    read_status();
    bus_read(2'd2, 32'd2);
    bus_read(2'd3, 32'd0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    read_status();

    repeat (40) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       bus_write(2'd2, $urandom);
        1:       glitch(4'($urandom_range(1, 15)), $urandom_range(1, 2));
        2, 3, 4: set_keys(4'($urandom_range(0, 15)));
        5, 6:    read_event();
        7:       read_status();
        8:       bus_write(2'd3, $urandom);
        default: begin
          bus_read(2'd2, {30'd0, m_ctrl});
          check_irq();
        end
      endcase
    end

    // Asynchronous reset with three queued events.
    bus_write(2'd2, 32'd1);
    set_keys(4'b0000);
    bus_write(2'd3, 32'd1);
    set_keys(4'b0111);
    check_irq();
    @(negedge clk);
    bus.avs_address = 2'd0;
    bus.avs_read    = 1'b1;
    @(posedge clk);
    #2;
    check("pre_reset_status", bus.avs_readdata, status_word());
    rst_n = 1'b0;
    #1;
    check("async_reset_readdata", bus.avs_readdata, 32'd0);
    check("async_reset_irq", {31'd0, bus.irq}, 32'd0);
    bus.avs_read = 1'b0;
    m_stable = 4'd0;
    m_ctrl   = 2'd0;
    m_ovf    = 1'b0;
    m_fifo.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    read_status();
    // Held keys are re-debounced as presses after reset.
    model_keys(4'b0111);
    repeat (25) @(negedge clk);
    read_status();
    repeat (3) read_event();
    read_status();
    check_irq();

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_responses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
